// File: rtl/nes_pad_reader.sv
// nes_pad_reader
//   Polls an NES-style serial gamepad at a fixed frame rate. Generates the
//   pad's latch and shift-clock strobes, deserialises the active-low data
//   line and publishes an active-high button byte with a one-cycle strobe.
//
// Ports
//   clk               in   system clock (50 MHz)
//   reset             in   asynchronous active-low reset
//   pad_data          in   serial data from pad, 0 = pressed, async to clk
//   pad_latch         out  parallel-load strobe to pad
//   pad_clk           out  shift clock to pad (pad advances on rising edge)
//   controller_report out  buttons: 0 A,1 B,2 Sel,3 Start,4 Up,5 Down,6 Left,7 Right
//   report_valid      out  one-cycle pulse with each controller_report update
//
// state  | meaning
// IDLE   | waiting for a poll tick
// LATCH  | pad_latch high for 2*CLK_DIV cycles
// SETTLE | latch released, bit0 sampled on last cycle
// CLK_HI | pad_clk high for CLK_DIV cycles
// CLK_LO | pad_clk low, bit[idx] sampled on last cycle
// DONE   | publish shift register, pulse report_valid
module nes_pad_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] controller_report,
  output logic       report_valid
);

  localparam int PW  = $clog2(POLL_CYCLES);
  localparam int PHW = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, LATCH, SETTLE, CLK_HI, CLK_LO, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     report_q, report_d;
  logic           valid_q, valid_d;
  logic           latch_q, latch_d;
  logic           pclk_q, pclk_d;
  logic           sync1_q, sync2_q;
  logic           tick;
  logic           phase_last;

  assign tick = (poll_q == PW'(POLL_CYCLES - 1));
  assign poll_d = tick ? '0 : poll_q + PW'(1);

  // LATCH spans two phases, every other state one.
  assign phase_last = (state_q == LATCH) ? (phase_q == PHW'(2 * CLK_DIV - 1))
                                         : (phase_q == PHW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PHW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (tick) state_d = LATCH;
      end
      LATCH: begin
        if (phase_last) begin
          state_d = SETTLE;
          phase_d = '0;
        end
      end
      SETTLE: begin
        if (phase_last) begin
          shift_d[0] = ~sync2_q;
          idx_d      = 3'd1;
          state_d    = CLK_HI;
          phase_d    = '0;
        end
      end
      CLK_HI: begin
        if (phase_last) begin
          state_d = CLK_LO;
          phase_d = '0;
        end
      end
      CLK_LO: begin
        if (phase_last) begin
          shift_d[idx_q] = ~sync2_q;
          phase_d        = '0;
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = CLK_HI;
          end
        end
      end
      DONE: begin
        phase_d = '0;
        idx_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        phase_d = '0;
        idx_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they change on the
  // same edge as the state they belong to.
  assign latch_d  = (state_d == LATCH);
  assign pclk_d   = (state_d == CLK_HI);
  assign valid_d  = (state_q == DONE);
  assign report_d = (state_q == DONE) ? shift_q : report_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      poll_q   <= '0;
      phase_q  <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      report_q <= 8'h00;
      valid_q  <= 1'b0;
      latch_q  <= 1'b0;
      pclk_q   <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      report_q <= report_d;
      valid_q  <= valid_d;
      latch_q  <= latch_d;
      pclk_q   <= pclk_d;
      sync1_q  <= pad_data;
      sync2_q  <= sync1_q;
    end
  end

  assign pad_latch         = latch_q;
  assign pad_clk           = pclk_q;
  assign controller_report = report_q;
  assign report_valid      = valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;
  localparam int D  = 4;
  localparam int P  = 200;
  localparam int RD = 17 * D + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pad_data = 1'b1;
  logic       pad_latch, pad_clk, report_valid;
  logic [7:0] controller_report;

  nes_pad_reader #(.CLK_DIV(D), .POLL_CYCLES(P)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .controller_report(controller_report), .report_valid(report_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int reads_done = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (report_valid === 1'b1) nvalid++;

  // Pad model: loads on latch, presents bit0 first, shifts on pad_clk rise.
  logic [7:0] buttons = 8'h00;
  int pad_idx = 0;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx = 0;
    else if (pad_idx < 8) pad_idx++;
  end

  // Line driver: true pad level near each sample point, random noise
  // elsewhere when noise is enabled. Sample edges sit at 3D+2Dk after the
  // latch rise.
  bit noise_en = 1'b0;
  int off = 1000;
  logic latch_prev = 1'b0;
  bit guard;
  logic pad_true;
  always @(negedge clk) begin
    if (pad_latch === 1'b1 && latch_prev !== 1'b1) off = 0;
    else off++;
    latch_prev = pad_latch;
    guard = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (off + 1 >= 3*D + 2*D*k - 4 && off + 1 <= 3*D + 2*D*k) guard = 1'b1;
    end
    pad_true = (pad_idx < 8) ? ~buttons[pad_idx[2:0]] : 1'b0;
    if (noise_en && !guard) pad_data = 1'($urandom_range(0, 1));
    else pad_data = pad_true;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pad_latch !== 1'b1 && n < 2000);
  endtask

  // One complete read: the report must equal the buttons held at latch time
  // and arrive 17*D+1 cycles after the latch rise as a single pulse.
  task automatic run_read(input logic [7:0] btn, input string tag,
                          output int vcyc, output int gap);
    int lat;
    int n;
    buttons = btn;
    wait_latch(gap);
    lat = cyc;
    check({tag, "_latch"}, 32'(pad_latch), 32'd1);
    n = 0;
    while (report_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vcyc = cyc;
    check({tag, "_dt"}, vcyc - lat, RD);
    check({tag, "_rep"}, 32'(controller_report), 32'(btn));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(report_valid), 32'd0);
    reads_done++;
  endtask

  initial begin
    int n, v1, v2, v3, g;
    int bad_l, bad_c, bad_v, ones_l, rises_c, bad_hold;
    logic prev_c;
    logic [7:0] r;

    // 1: reset state, first latch timing, strobe waveform
    repeat (3) @(negedge clk);
    check("rst_outs", {21'd0, pad_latch, pad_clk, report_valid, controller_report}, 32'd0);
    buttons = 8'h00;
    reset = 1'b1;
    wait_latch(n);
    check("first_latch", n, P);
    bad_l = 0; bad_c = 0; bad_v = 0; ones_l = 0; rises_c = 0; prev_c = 1'b0;
    for (int c = 0; c < 72; c++) begin
      if (pad_latch !== 1'(c < 2*D)) bad_l++;
      if (pad_clk !== 1'(c >= 3*D && c < 17*D && ((c - 3*D) % (2*D)) < D)) bad_c++;
      if (report_valid !== 1'(c == RD)) bad_v++;
      if (pad_latch === 1'b1) ones_l++;
      if (pad_clk === 1'b1 && prev_c === 1'b0) rises_c++;
      prev_c = pad_clk;
      @(negedge clk);
    end
    reads_done++;
    check("trace_latch", bad_l, 0);
    check("trace_clk", bad_c, 0);
    check("trace_valid", bad_v, 0);
    check("latch_len", ones_l, 2*D);
    check("clk_pulses", rises_c, 7);
    check("first_rep", 32'(controller_report), 32'h00);

    // 2: A+Start, report holds between reads
    run_read(8'h09, "ast", v1, g);
    bad_hold = 0;
    repeat (100) begin
      @(negedge clk);
      if (controller_report !== 8'h09 || report_valid !== 1'b0) bad_hold++;
    end
    check("ast_hold", bad_hold, 0);

    // 3: Up across three polls, pulses one poll period apart
    run_read(8'h10, "up1", v1, g);
    run_read(8'h10, "up2", v2, g);
    run_read(8'h10, "up3", v3, g);
    check("up_gap12", v2 - v1, P);
    check("up_gap23", v3 - v2, P);

    // 4: no pad, stuck low, single-button walk
    run_read(8'h00, "nopad", v1, g);
    run_read(8'hFF, "stuck", v1, g);
    for (int b = 0; b < 8; b++) begin
      r = 8'h01 << b;
      run_read(r, $sformatf("walk%0d", b), v1, g);
    end

    // 5: reset during the 4th pad_clk high phase
    run_read(8'h09, "pre_abort", v1, g);
    wait_latch(n);
    repeat (37) @(negedge clk);
    check("hi4_pre", 32'(pad_clk), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_outs", {21'd0, pad_latch, pad_clk, report_valid, controller_report}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_hold", {21'd0, pad_latch, pad_clk, report_valid, controller_report}, 32'd0);
    reset = 1'b1;
    run_read(8'h09, "post_abort", v1, g);
    check("post_abort_gap", g, P);

    // 6: noisy line away from sample points, random buttons
    noise_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = 8'($urandom);
      run_read(r, $sformatf("noise%0d", i), v1, g);
    end
    noise_en = 1'b0;

    check("nvalid", nvalid, reads_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
